mdu_seq: RTL

Multi-cycle multiply/divide sequencer beside the EXE stage. It handles MULT, MULTU, DIV and DIVU operations and writes the HI/LO results.
- Multiply takes a fixed MUL_LAT cycles. Divide is an iterative radix-2 restoring divider.
- `busy` holds the EXE stage (ready_go low) while an operation is in flight.
- A one-cycle result strobe drives the hi/lo register write enables.
- Pipeline flush cancels an in-flight operation without writing.

---
 rtl/mdu_pkg.sv | 28 ++
 rtl/mdu_div_step.sv | 27 ++
 rtl/mdu_seq.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings and sizing helpers for the multiply/divide sequencer.
package mdu_pkg;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'd0,
        MDU_MULTU = 2'd1,
        MDU_DIV   = 2'd2,
        MDU_DIVU  = 2'd3
    } mdu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } mdu_state_e;

    localparam int MDU_WIDTH = 32;

    // The cycle counter must hold the longer of the multiply and divide loads.
    function automatic int mdu_cnt_w(input int width, input int mul_lat);
        int n;
        n = (width > mul_lat) ? width : mul_lat;
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    localparam int MDU_CNT_W = mdu_cnt_w(MDU_WIDTH, 1);

endpackage

// File: rtl/mdu_div_step.sv
// One combinational radix-2 restoring division step: shift in the next
// dividend bit, trial-subtract the divisor, keep or restore the remainder.
module mdu_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] dvd,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] dvd_next,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    assign shifted = {rem, dvd[WIDTH-1]};
    assign diff    = shifted - {1'b0, dvs};

    // rem < dvs always holds, so a borrow shows up in the extra top bit.
    assign q_bit    = ~diff[WIDTH];
    assign rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

    // LSB left clear; the caller packs the quotient bit into the vacated slot.
    assign dvd_next = {dvd[WIDTH-2:0], 1'b0};

endmodule

// File: rtl/mdu_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer producing HI/LO with a one-cycle strobe.
// Optional build macro MDU_DIV0_FASTPATH_EN: zero-divisor divides skip CALC.
module mdu_seq
    import mdu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             cancel,
    output logic             busy,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo,
    output logic             div_zero
);

    localparam int CNT_W = mdu_cnt_w(WIDTH, MUL_LAT);

    mdu_state_e       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg;
    mdu_op_e          op_reg;
    logic [WIDTH-1:0] a_reg, b_reg;
    logic [WIDTH-1:0] rem_reg, dvd_reg, dvs_reg;
    logic             q_neg_reg, r_neg_reg, dvs_zero_reg;
    logic [WIDTH-1:0] res_hi_reg, res_lo_reg;
    logic             div_zero_reg;

    logic             load_op, load_res;
    logic [WIDTH-1:0] hi_next, lo_next;
    logic             dz_next;

    // Operand conditioning in the start cycle.
    logic             start_is_div, start_signed_div;
    logic             a_neg_in, b_neg_in;
    logic [WIDTH-1:0] a_mag_in, b_mag_in;

    assign start_is_div     = (op == MDU_DIV) || (op == MDU_DIVU);
    assign start_signed_div = (op == MDU_DIV);
    assign a_neg_in         = start_signed_div & src_a[WIDTH-1];
    assign b_neg_in         = start_signed_div & src_b[WIDTH-1];
    assign a_mag_in         = a_neg_in ? -src_a : src_a;
    assign b_mag_in         = b_neg_in ? -src_b : src_b;

    // Divider step on the current partial state.
    logic [WIDTH-1:0] rem_step, dvd_step;
    logic             q_step;
    logic [WIDTH-1:0] quo_step;

    mdu_div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_reg),
        .dvd      (dvd_reg),
        .dvs      (dvs_reg),
        .rem_next (rem_step),
        .dvd_next (dvd_step),
        .q_bit    (q_step)
    );

    assign quo_step = dvd_step | WIDTH'(q_step);

    // Product of the latched operands, sign-extended to 2*WIDTH for MULT.
    logic              op_is_div, mul_signed;
    logic [2*WIDTH-1:0] a_ext, b_ext, product;

    assign op_is_div  = (op_reg == MDU_DIV) || (op_reg == MDU_DIVU);
    assign mul_signed = (op_reg == MDU_MULT);
    assign a_ext      = {{WIDTH{mul_signed & a_reg[WIDTH-1]}}, a_reg};
    assign b_ext      = {{WIDTH{mul_signed & b_reg[WIDTH-1]}}, b_reg};
    assign product    = a_ext * b_ext;

    logic [WIDTH-1:0] q_fix, r_fix;
    assign q_fix = q_neg_reg ? -quo_step : quo_step;
    assign r_fix = r_neg_reg ? -rem_step : rem_step;

    always_comb begin
        hi_next = res_hi_reg;
        lo_next = res_lo_reg;
        dz_next = div_zero_reg;
`ifdef MDU_DIV0_FASTPATH_EN
        if (state_reg == S_IDLE) begin
            hi_next = src_a;
            lo_next = '1;
            dz_next = 1'b1;
        end else
`endif
        if (op_is_div) begin
            if (dvs_zero_reg) begin
                hi_next = a_reg;
                lo_next = '1;
                dz_next = 1'b1;
            end else begin
                hi_next = r_fix;
                lo_next = q_fix;
                dz_next = 1'b0;
            end
        end else begin
            hi_next = product[2*WIDTH-1:WIDTH];
            lo_next = product[WIDTH-1:0];
            dz_next = 1'b0;
        end
    end

    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        load_op    = 1'b0;
        load_res   = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start && !cancel) begin
                    busy    = 1'b1;
                    load_op = 1'b1;
`ifdef MDU_DIV0_FASTPATH_EN
                    if (start_is_div && (src_b == '0)) begin
                        state_next = S_DONE;
                        load_res   = 1'b1;
                    end else begin
                        state_next = S_CALC;
                    end
`else
                    state_next = S_CALC;
`endif
                end
            end
            S_CALC: begin
                busy = 1'b1;
                if (cancel) begin
                    state_next = S_IDLE;
                end else if (cnt_reg == '0) begin
                    state_next = S_DONE;
                    load_res   = 1'b1;
                end
            end
            // The write is already committed by the EXE handshake; cancel is ignored.
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg      <= '0;
            op_reg       <= MDU_MULT;
            a_reg        <= '0;
            b_reg        <= '0;
            rem_reg      <= '0;
            dvd_reg      <= '0;
            dvs_reg      <= '0;
            q_neg_reg    <= 1'b0;
            r_neg_reg    <= 1'b0;
            dvs_zero_reg <= 1'b0;
            res_hi_reg   <= '0;
            res_lo_reg   <= '0;
            div_zero_reg <= 1'b0;
        end else begin
            if (load_op) begin
                a_reg        <= src_a;
                b_reg        <= src_b;
                op_reg       <= mdu_op_e'(op);
                cnt_reg      <= start_is_div ? CNT_W'(WIDTH - 1) : CNT_W'(MUL_LAT - 1);
                rem_reg      <= '0;
                dvd_reg      <= a_mag_in;
                dvs_reg      <= b_mag_in;
                q_neg_reg    <= a_neg_in ^ b_neg_in;
                r_neg_reg    <= a_neg_in;
                dvs_zero_reg <= (src_b == '0);
            end else if (state_reg == S_CALC) begin
                cnt_reg <= cnt_reg - CNT_W'(1);
                rem_reg <= rem_step;
                dvd_reg <= quo_step;
            end
            if (load_res) begin
                res_hi_reg   <= hi_next;
                res_lo_reg   <= lo_next;
                div_zero_reg <= dz_next;
            end
        end
    end

    assign res_valid = (state_reg == S_DONE);
    assign res_hi    = res_hi_reg;
    assign res_lo    = res_lo_reg;
    assign div_zero  = div_zero_reg;

endmodule
